// File: rtl/serial_bus_master_marine_radar.sv
// Host-side settings bus master: turns 3-wire host frames into the serial_addr/serial_data/serial_strobe
// write bus and shifts one of four latched status words back out on SDO for read frames.
module serial_bus_master_marine_radar #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] RB_BASE     = 7'h7C
) (
  input  logic        master_clk,
  input  logic        reset_n,
  input  logic        serial_enable,
  input  logic        serial_clock,
  input  logic        serial_data_in,
  output logic        serial_data_out,
  output logic        serial_data_oe,
  input  logic [31:0] readback_0,
  input  logic [31:0] readback_1,
  input  logic [31:0] readback_2,
  input  logic [31:0] readback_3,
  output logic [6:0]  serial_addr,
  output logic [31:0] serial_data,
  output logic        serial_strobe,
  output logic        frame_error
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, STROBE} state_t;

  localparam logic [5:0] FRAME_BITS = 6'd40;
  localparam logic [5:0] RD_BITS    = 6'd32;

  state_t state, state_next;

  logic [SYNC_STAGES:0]   sen_sync, sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sen_s, sclk_s, sdi_s;
  logic                   sen_rise, sen_fall, sclk_rise, sclk_fall;

  logic [5:0]  bit_cnt;
  logic [5:0]  rd_cnt;
  logic [6:0]  addr_sr;
  logic [31:0] data_sr;
  logic [31:0] rb_word;
  logic [31:0] rb_sel;
  logic [6:0]  rb_addr, rb_off;
  logic        last_addr_bit, rw_bit;

  // The extra top flop of SEN/SCLK holds the previous synchronised level for edge detection
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_sync  <= '0;
      sclk_sync <= '0;
      sdi_sync  <= '0;
    end else begin
      sen_sync  <= {sen_sync[SYNC_STAGES-1:0], serial_enable};
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], serial_clock};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], serial_data_in};
    end
  end

  assign sen_s     = sen_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sen_rise  = sen_s & ~sen_sync[SYNC_STAGES];
  assign sen_fall  = ~sen_s & sen_sync[SYNC_STAGES];
  assign sclk_rise = sen_s & sclk_s & ~sclk_sync[SYNC_STAGES];
  assign sclk_fall = sen_s & ~sclk_s & sclk_sync[SYNC_STAGES];

  // The R/W bit sits at the top of the address shifter until the 8th bit pushes it out
  assign last_addr_bit = (state == ADDR) && sclk_rise && (bit_cnt == 6'd7);
  assign rw_bit        = addr_sr[6];
  assign rb_addr       = {addr_sr[5:0], sdi_s};
  assign rb_off        = rb_addr - RB_BASE;

  always_comb begin
    rb_sel = 32'h0;
    if (rb_off[6:2] == 5'd0) begin
      case (rb_off[1:0])
        2'd0:    rb_sel = readback_0;
        2'd1:    rb_sel = readback_1;
        2'd2:    rb_sel = readback_2;
        default: rb_sel = readback_3;
      endcase
    end
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (sen_rise) begin
      state_next = ADDR;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ADDR: begin
          if (sen_fall)           state_next = IDLE;
          else if (last_addr_bit) state_next = rw_bit ? RDATA : WDATA;
        end
        WDATA: begin
          if (sen_fall) state_next = (bit_cnt == FRAME_BITS) ? STROBE : IDLE;
        end
        RDATA: begin
          if (sen_fall) state_next = IDLE;
        end
        STROBE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    serial_strobe   = (state == STROBE);
    serial_data_oe  = (state == RDATA) && (rd_cnt != RD_BITS);
    serial_data_out = serial_data_oe & rb_word[31];
  end

  // Shifters, counters and the write bus; serial_addr/data only move when entering STROBE
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      rd_cnt      <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      rb_word     <= '0;
      serial_addr <= '0;
      serial_data <= '0;
      frame_error <= 1'b0;
    end else if (sen_rise) begin
      bit_cnt <= '0;
      rd_cnt  <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      rb_word <= '0;
    end else begin
      case (state)
        ADDR: begin
          if (sen_fall) begin
            frame_error <= 1'b1;
          end else if (sclk_rise) begin
            addr_sr <= {addr_sr[5:0], sdi_s};
            bit_cnt <= bit_cnt + 6'd1;
            if (last_addr_bit && rw_bit) rb_word <= rb_sel;
          end
        end
        WDATA: begin
          if (sen_fall) begin
            if (bit_cnt == FRAME_BITS) begin
              serial_addr <= addr_sr;
              serial_data <= data_sr;
            end else begin
              frame_error <= 1'b1;
            end
          end else if (sclk_rise && (bit_cnt != FRAME_BITS)) begin
            data_sr <= {data_sr[30:0], sdi_s};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        RDATA: begin
          if (sen_fall) begin
            frame_error <= 1'b0;
          end else if (sclk_fall && (rd_cnt != RD_BITS)) begin
            rb_word <= {rb_word[30:0], 1'b0};
            rd_cnt  <= rd_cnt + 6'd1;
          end
        end
        STROBE:  frame_error <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
